f1_reaction_timer: RTL and testbench
====================================

# f1_reaction_timer

Consumer of the F1 start-light bar. Watches the 8-bit light pattern produced by the light sequencer, detects the "all on → lights out" event, and measures the driver's reaction time in time-base ticks until the trigger button is pressed. Flags a false start if the button is pressed while the lights are still lit. Sits between the light sequencer output and the display/score logic.

## Interface
- CNT_WIDTH, 16, width of reaction-time counter and result.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  time-base strobe, one clk wide (nominally 1 ms); counter advances only on tick.
- lights  in  8  light bar from sequencer; bit 0 lights first, 8'hFF = all on, 8'h00 = all off.
- trigger  in  1  driver button level, already synchronous and debounced upstream.
- react_time  out  CNT_WIDTH  last valid reaction time in ticks; held until next valid result.
- result_valid  out  1  one-cycle pulse when react_time is updated.
- false_start  out  1  level, high while in FAULT.
- busy  out  1  high in SEQ, ALL_ON, TIMING.
- lit_count  out  4  registered popcount of lights, 0..8.

## Operation
- Trigger edge: trig_q registered copy of trigger; press = trigger & ~trig_q. Only press events matter, never level.
- States: IDLE, SEQ, ALL_ON, TIMING, DONE, FAULT.
- IDLE: lights != 0 → SEQ. press ignored.
- SEQ: press → FAULT (highest priority). else lights == 8'hFF → ALL_ON. else lights == 0 → IDLE (aborted sequence, no result).
- ALL_ON: press → FAULT. else lights == 0 → TIMING, counter cleared to 0.
- TIMING: tick → counter + 1, saturating at all-ones (no wrap). press → DONE; react_time <= counter + tick (a tick in the press cycle is counted); result_valid pulses. lights != 0 without press → SEQ, react_time unchanged, no pulse.
- DONE: lights != 0 → SEQ; otherwise hold.
- FAULT: false_start = 1. Exit to IDLE when lights == 0 and trigger == 0; false_start clears on the same edge. Further presses ignored.
- Priority of simultaneous events in one cycle: press > lights change > tick.
- Non-thermometer light patterns are not checked; only the 0 / nonzero / 8'hFF distinctions drive the FSM.
- lit_count = number of ones in lights, updated every cycle regardless of state.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, counter 0, trig_q 0, react_time 0, result_valid 0, false_start 0, busy 0, lit_count 0.
- All outputs registered; no combinational input→output paths.
- Press sampled at posedge N → state, react_time, and result_valid update at posedge N; result_valid low again after posedge N+1.
- lit_count lags lights by one cycle.
- Lights-out seen at posedge N → counter = 0 after N; first tick at posedge N+1 or later gives 1.
- Trigger high at reset release yields a press in the first cycle; harmless because the FSM is in IDLE.
- Reset asserted mid-TIMING aborts the measurement; react_time returns to 0.

## Structure
- Package f1_pkg: state enum (IDLE, SEQ, ALL_ON, TIMING, DONE, FAULT), N_LIGHTS = 8, LIGHTS_ALL_ON = 8'hFF, LIGHTS_OFF = 8'h00.
- Sub-module edge_detect (rising-edge pulse from a level, async active-low reset) for trigger; reusable for other buttons.
- Counter, FSM and popcount stay in the top module.

## Test plan
- Normal run: lights 01,03,…,FF then 00, tick every cycle, press 25 cycles after lights-out → react_time = 25, result_valid high for exactly 1 cycle, false_start 0.
- False start: press while lights = 8'h07 → FAULT, false_start = 1, no result_valid. Release trigger with lights = 0 → IDLE, false_start 0. react_time keeps its old value.
- Saturation with CNT_WIDTH = 4: 20 ticks after lights-out, then press → react_time = 15.
- Simultaneous press and tick in the same cycle, with counter at 7 → react_time = 8.
- Abort: lights go 8'h0F → 8'h00 (never FF) → IDLE, busy 0. Later press → no result_valid.
- Async reset mid-TIMING with counter at 10 → all outputs 0 immediately, without waiting for a clock edge. After release, a full sequence measures correctly from 0.

Source files
------------

// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and constants for the F1 start-light reaction timer
//
// Purpose: FSM state encoding and light-bar constants used by f1_reaction_timer.
// Ports:   none (package).

package f1_pkg;

  localparam int N_LIGHTS = 8;

  localparam logic [N_LIGHTS-1:0] LIGHTS_ALL_ON = 8'hFF;
  localparam logic [N_LIGHTS-1:0] LIGHTS_OFF    = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEQ    = 3'd1,
    ALL_ON = 3'd2,
    TIMING = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge pulse from a synchronous level
//
// Purpose: produces a one-cycle pulse in the cycle a level input goes high.
//          The input must already be synchronous to clk (and debounced).
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset (clears the history bit)
//   level  in  1  level to watch
//   pulse  out 1  level & ~previous level (combinational from level and a flop)

module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// rtl/f1_reaction_timer.sv - start-light watcher and driver reaction-time counter
//
// Purpose: watches the 8-bit light bar, arms on all-on, starts timing on
//          lights-out and measures ticks until the trigger button is pressed.
//          A press while lights are lit is a false start.
// Ports:
//   clk           in  1          system clock
//   rst_n         in  1          asynchronous active-low reset
//   tick          in  1          time-base strobe, one clk wide
//   lights        in  8          light bar, 8'hFF all on, 8'h00 all off
//   trigger       in  1          driver button level (synchronous, debounced)
//   react_time    out CNT_WIDTH  last valid reaction time in ticks
//   result_valid  out 1          one-cycle pulse when react_time updates
//   false_start   out 1          high while in FAULT
//   busy          out 1          high in SEQ, ALL_ON, TIMING
//   lit_count     out 4          registered popcount of lights

module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [7:0]           lights,
  input  logic                 trigger,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 result_valid,
  output logic                 false_start,
  output logic                 busy,
  output logic [3:0]           lit_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] counter_inc;
  logic [CNT_WIDTH-1:0] counter_at_press;
  logic [3:0]           lit_nxt;
  logic                 press;
  logic                 lights_off;
  logic                 lights_full;

  edge_detect u_trig_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (trigger),
    .pulse (press)
  );

  assign lights_off  = (lights == LIGHTS_OFF);
  assign lights_full = (lights == LIGHTS_ALL_ON);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign counter_inc = (counter == CNT_MAX) ? counter : counter + 1'b1;

  // A tick landing in the press cycle still counts toward the result.
  assign counter_at_press = tick ? counter_inc : counter;

  always_comb begin
    lit_nxt = 4'd0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      lit_nxt = lit_nxt + {3'b000, lights[i]};
    end
  end

  // Next state. Within each state a press outranks a lights change,
  // which outranks a tick.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!lights_off) state_nxt = SEQ;
      end
      SEQ: begin
        if (press)            state_nxt = FAULT;
        else if (lights_full) state_nxt = ALL_ON;
        else if (lights_off)  state_nxt = IDLE;
      end
      ALL_ON: begin
        if (press)           state_nxt = FAULT;
        else if (lights_off) state_nxt = TIMING;
      end
      TIMING: begin
        if (press)            state_nxt = DONE;
        else if (!lights_off) state_nxt = SEQ;
      end
      DONE: begin
        if (!lights_off) state_nxt = SEQ;
      end
      FAULT: begin
        // Wait for both a dark bar and a released button so a held
        // button cannot fall straight into the next sequence.
        if (lights_off && !trigger) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counter      <= '0;
      react_time   <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      busy         <= 1'b0;
      lit_count    <= 4'd0;
    end else begin
      state        <= state_nxt;
      lit_count    <= lit_nxt;
      result_valid <= 1'b0;

      // Outputs are registered from the next state so they line up with it.
      false_start <= (state_nxt == FAULT);
      busy        <= (state_nxt == SEQ) || (state_nxt == ALL_ON) ||
                     (state_nxt == TIMING);

      case (state)
        ALL_ON: begin
          if (!press && lights_off) counter <= '0;
        end
        TIMING: begin
          if (press) begin
            react_time   <= counter_at_press;
            result_valid <= 1'b1;
          end else if (lights_off && tick) begin
            counter <= counter_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb/tb_f1_reaction_timer.sv - self-checking bench for f1_reaction_timer

module tb_f1_reaction_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [7:0]  lights;
  logic        trigger;

  logic [15:0] react_time;
  logic        result_valid, false_start, busy;
  logic [3:0]  lit_count;

  logic [3:0]  react_time4;
  logic        result_valid4, false_start4, busy4;
  logic [3:0]  lit_count4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  f1_reaction_timer #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .lights(lights), .trigger(trigger),
    .react_time(react_time), .result_valid(result_valid),
    .false_start(false_start), .busy(busy), .lit_count(lit_count)
  );

  f1_reaction_timer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .lights(lights), .trigger(trigger),
    .react_time(react_time4), .result_valid(result_valid4),
    .false_start(false_start4), .busy(busy4), .lit_count(lit_count4)
  );

  // Reference model: phases of a race start, elapsed ticks kept as an
  // unbounded integer and clipped to the counter width only when compared.
  localparam int P_DARK = 0, P_LIGHTING = 1, P_ARMED = 2,
                 P_RUNNING = 3, P_RESULT = 4, P_JUMPED = 5;

  int   m_phase, m_elapsed, m_result, m_lit;
  logic m_trig, m_rv;
  logic m_press;

  assign m_press = trigger & ~m_trig;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= P_DARK;
      m_elapsed <= 0;
      m_result  <= 0;
      m_lit     <= 0;
      m_trig    <= 1'b0;
      m_rv      <= 1'b0;
    end else begin
      m_trig <= trigger;
      m_lit  <= $countones(lights);
      m_rv   <= 1'b0;
      case (m_phase)
        P_DARK:     if (lights != 0) m_phase <= P_LIGHTING;
        P_LIGHTING: begin
          if (m_press)              m_phase <= P_JUMPED;
          else if (lights == 8'hFF) m_phase <= P_ARMED;
          else if (lights == 0)     m_phase <= P_DARK;
        end
        P_ARMED: begin
          if (m_press) m_phase <= P_JUMPED;
          else if (lights == 0) begin
            m_phase   <= P_RUNNING;
            m_elapsed <= 0;
          end
        end
        P_RUNNING: begin
          if (m_press) begin
            m_result <= m_elapsed + int'(tick);
            m_rv     <= 1'b1;
            m_phase  <= P_RESULT;
          end else if (lights != 0) begin
            m_phase <= P_LIGHTING;
          end else begin
            m_elapsed <= m_elapsed + int'(tick);
          end
        end
        P_RESULT: if (lights != 0) m_phase <= P_LIGHTING;
        default:  if (lights == 0 && !trigger) m_phase <= P_DARK;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      automatic logic exp_busy = (m_phase == P_LIGHTING) || (m_phase == P_ARMED) ||
                                 (m_phase == P_RUNNING);
      automatic logic exp_fs = (m_phase == P_JUMPED);
      check("react_time", 32'(react_time), 32'(clip(m_result, 65535)));
      check("result_valid", 32'(result_valid), 32'(m_rv));
      check("false_start", 32'(false_start), 32'(exp_fs));
      check("busy", 32'(busy), 32'(exp_busy));
      check("lit_count", 32'(lit_count), 32'(m_lit));
      check("react_time4", 32'(react_time4), 32'(clip(m_result, 15)));
      check("result_valid4", 32'(result_valid4), 32'(m_rv));
      check("false_start4", 32'(false_start4), 32'(exp_fs));
      check("busy4", 32'(busy4), 32'(exp_busy));
    end
  end

  task automatic cyc(input logic [7:0] l, input logic t, input logic k);
    lights = l; trigger = t; tick = k;
    @(posedge clk); #1;
  endtask

  task automatic run_lights(input logic k);
    for (int i = 0; i < 8; i++) cyc(8'((16'd1 << (i + 1)) - 16'd1), 1'b0, k);
  endtask

  initial begin
    rst_n = 1'b0; lights = 8'h00; trigger = 1'b0; tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset react_time", 32'(react_time), 0);
    check("reset busy", 32'(busy), 0);
    check("reset lit_count", 32'(lit_count), 0);
    rst_n = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);

    // Normal run: press 25 cycles after lights-out, tick every cycle.
    run_lights(1'b1);
    check("all_on busy", 32'(busy), 1);
    check("all_on lit_count", 32'(lit_count), 8);
    cyc(8'h00, 1'b0, 1'b1);
    repeat (24) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    check("normal react_time", 32'(react_time), 25);
    check("normal result_valid", 32'(result_valid), 1);
    check("normal false_start", 32'(false_start), 0);
    check("model result", 32'(m_result), 25);
    cyc(8'h00, 1'b1, 1'b1);
    check("normal rv drop", 32'(result_valid), 0);
    cyc(8'h00, 1'b0, 1'b0);

    // False start at 8'h07.
    cyc(8'h01, 1'b0, 1'b0);
    cyc(8'h03, 1'b0, 1'b0);
    cyc(8'h07, 1'b1, 1'b0);
    check("fs false_start", 32'(false_start), 1);
    check("fs result_valid", 32'(result_valid), 0);
    check("fs busy", 32'(busy), 0);
    cyc(8'h00, 1'b1, 1'b0);
    check("fs held", 32'(false_start), 1);
    cyc(8'h00, 1'b0, 1'b0);
    check("fs cleared", 32'(false_start), 0);
    check("fs react kept", 32'(react_time), 25);

    // Saturation: 20 ticks, press without tick.
    run_lights(1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    repeat (20) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    check("sat react_time4", 32'(react_time4), 15);
    check("sat react_time16", 32'(react_time), 20);
    cyc(8'h00, 1'b0, 1'b0);

    // Press and tick together with counter at 7.
    run_lights(1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    repeat (7) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    check("simul react_time", 32'(react_time), 8);
    check("simul react_time4", 32'(react_time4), 8);
    cyc(8'h00, 1'b0, 1'b0);

    // Aborted sequence.
    cyc(8'h01, 1'b0, 1'b0);
    cyc(8'h03, 1'b0, 1'b0);
    cyc(8'h07, 1'b0, 1'b0);
    cyc(8'h0F, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    check("abort busy", 32'(busy), 0);
    cyc(8'h00, 1'b1, 1'b0);
    check("abort no result", 32'(result_valid), 0);
    check("abort no fault", 32'(false_start), 0);
    cyc(8'h00, 1'b0, 1'b0);

    // Asynchronous reset with the counter at 10.
    run_lights(1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    repeat (10) cyc(8'h00, 1'b0, 1'b1);
    check("pre-reset busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async react_time", 32'(react_time), 0);
    check("async busy", 32'(busy), 0);
    check("async lit_count", 32'(lit_count), 0);
    check("async react_time4", 32'(react_time4), 0);
    check("async false_start", 32'(false_start), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
    run_lights(1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    repeat (4) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    check("post-reset react_time", 32'(react_time), 5);
    check("post-reset result_valid", 32'(result_valid), 1);
    cyc(8'h0F, 1'b0, 1'b0);
    check("lit_count 0F", 32'(lit_count), 4);
    check("busy after reseq", 32'(busy), 1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
